// File: rtl/ysyx_220066_mem_arb.sv
// ysyx_220066_mem_arb: round-robin arbiter that merges N requesters (ifetch, dmem read,
// dmem write by convention) onto one shared memory bus. It keeps one transaction in
// flight, and both the request fields and the response are registered.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a transaction that stays in REQ/WAIT
// for TIMEOUT_CYC cycles. The abort returns an error response.
module ysyx_220066_mem_arb #(
   parameter int unsigned N_PORTS     = 3,
   parameter int unsigned ADDR_W      = 64,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_PORTS-1:0]        up_req,
   input  logic [N_PORTS-1:0]        up_wr,
   input  logic [N_PORTS*ADDR_W-1:0] up_addr,
   input  logic [N_PORTS*3-1:0]      up_op,
   input  logic [N_PORTS*DATA_W-1:0] up_wdata,
   output logic [N_PORTS-1:0]        up_gnt,
   output logic [N_PORTS-1:0]        up_rvalid,
   output logic [DATA_W-1:0]         up_rdata,
   output logic                      up_error,
   output logic                      bus_req,
   output logic                      bus_wr,
   output logic [ADDR_W-1:0]         bus_addr,
   output logic [2:0]                bus_op,
   output logic [DATA_W-1:0]         bus_wdata,
   input  logic                      bus_ready,
   input  logic                      bus_rvalid,
   input  logic [DATA_W-1:0]         bus_rdata,
   input  logic                      bus_error
);
   localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_e;

   state_e              state_q,  state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    owner_q,  owner_d;
   logic                first_q,  first_d;
   logic                wr_q,     wr_d;
   logic [ADDR_W-1:0]   addr_q,   addr_d;
   logic [2:0]          op_q,     op_d;
   logic [DATA_W-1:0]   wdata_q,  wdata_d;
   logic [DATA_W-1:0]   rdata_q,  rdata_d;
   logic                error_q,  error_d;

   logic                any_req;
   logic [IDX_W-1:0]    win_idx;
   logic                timeout;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Watchdog count: zero while idle (so zero on REQ entry), advances in REQ and WAIT
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE) begin
         cnt_d = '0;
      end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Watchdog register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   // Fires in the cycle whose closing edge brings the count to TIMEOUT_CYC
   assign timeout = (state_q == ST_REQ || state_q == ST_WAIT) &&
                    (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign timeout = 1'b0;
   // TIMEOUT_CYC has no effect unless the watchdog is compiled in
   if (TIMEOUT_CYC == 0) begin : g_timeout_unused
   end
`endif

   // Round-robin pick: first requesting port at or above rr_ptr, wrapping modulo N_PORTS
   always_comb begin
      int unsigned      cand;
      logic [IDX_W-1:0] cand_idx;
      any_req  = 1'b0;
      win_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         cand     = (32'(rr_ptr_q) + i) % N_PORTS;
         cand_idx = IDX_W'(cand);
         if (!any_req && up_req[cand_idx]) begin
            any_req = 1'b1;
            win_idx = cand_idx;
         end
      end
   end

   // Next-state and datapath latching
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      first_d  = 1'b0;
      wr_d     = wr_q;
      addr_d   = addr_q;
      op_d     = op_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      error_d  = error_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d  = ST_REQ;
               owner_d  = win_idx;
               first_d  = 1'b1;
               rr_ptr_d = (win_idx == IDX_W'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;
               wr_d     = up_wr[win_idx];
               addr_d   = up_addr[32'(win_idx)*ADDR_W +: ADDR_W];
               op_d     = up_op[32'(win_idx)*3 +: 3];
               wdata_d  = up_wdata[32'(win_idx)*DATA_W +: DATA_W];
            end
         end
         ST_REQ: begin
            if (bus_ready) begin
               if (bus_rvalid) begin
                  state_d = ST_RESP;
                  rdata_d = wr_q ? '0 : bus_rdata;
                  error_d = bus_error;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (timeout) begin
               state_d = ST_RESP;
               rdata_d = '0;
               error_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (bus_rvalid) begin
               state_d = ST_RESP;
               rdata_d = wr_q ? '0 : bus_rdata;
               error_d = bus_error;
            end else if (timeout) begin
               state_d = ST_RESP;
               rdata_d = '0;
               error_d = 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         first_q  <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         op_q     <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         first_q  <= first_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         op_q     <= op_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         error_q  <= error_d;
      end
   end

   // Outputs decoded from state; grant only in the first REQ cycle
   always_comb begin
      bus_req   = (state_q == ST_REQ);
      up_gnt    = '0;
      up_rvalid = '0;
      if (state_q == ST_REQ && first_q) up_gnt[owner_q] = 1'b1;
      if (state_q == ST_RESP)           up_rvalid[owner_q] = 1'b1;
      bus_wr    = wr_q;
      bus_addr  = addr_q;
      bus_op    = op_q;
      bus_wdata = wdata_q;
      up_rdata  = rdata_q;
      up_error  = error_q;
   end

endmodule
